// File: rtl/demux_array_pkg.sv
// Shared constants and helpers for the demux_array slice.
// Also provides the default data word width when no project-wide value is set.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package demux_array_pkg;

  localparam int         DROP_COUNT_WIDTH = 8;
  localparam logic [7:0] DROP_COUNT_MAX   = 8'hFF;

  // The drop counter sticks at its ceiling instead of wrapping to zero.
  function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(
    input logic [DROP_COUNT_WIDTH-1:0] value
  );
    return (value == DROP_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel of demux_array: a single-word holding register plus full flag.
// A load and a drain on the same edge replace the word without a bubble.
module demux_slot
  import demux_array_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  full;
  logic [DATA_WIDTH-1:0] data;

  // NOTE: the holding register is reset as well as the flag, so an idle channel reads zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end

  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/demux_array.sv
// Routes one input word stream to NUM_OUT single-word output channels by select index.
// Words addressed to a channel that does not exist are dropped and counted.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module demux_array
  import demux_array_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_OUT    = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_OUT)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [SEL_WIDTH-1:0]          in_sel,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic                          drop_pulse,
  output logic [DROP_COUNT_WIDTH-1:0]   drop_count
);

  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] chan_ready;
  logic [NUM_OUT-1:0] load;
  logic               sel_hit;
  logic               accept;
  logic               drop;

  // A full channel can still take a word if its sink drains on the same edge.
  assign chan_ready = ~full | out_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned.
  always_comb begin
    in_ready = 1'b1;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_sel == SEL_WIDTH'(k)) begin
        in_ready = chan_ready[k];
        sel_hit  = 1'b1;
      end
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !sel_hit;

  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      load[k] = accept && (in_sel == SEL_WIDTH'(k));
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (full[k]),
      .out_data  (out_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign out_valid = full;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop) begin
        drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_demux_array.sv
// Directed self-checking bench for demux_array: a 4-channel instance for routing
// and a 3-channel instance whose spare select code exercises the drop path.
module tb_demux_array;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        drop_pulse;
  logic [7:0]  drop_count;

  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [23:0] out_data3;
  logic        drop_pulse3;
  logic [7:0]  drop_count3;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux_array #(.DATA_WIDTH(DW), .NUM_OUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  demux_array #(.DATA_WIDTH(DW), .NUM_OUT(3)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .in_data    (in_data3),
    .in_sel     (in_sel3),
    .out_valid  (out_valid3),
    .out_ready  (out_ready3),
    .out_data   (out_data3),
    .drop_pulse (drop_pulse3),
    .drop_count (drop_count3)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_sel     = 2'd2;
    out_ready  = 4'b0000;
    in_valid3  = 1'b0;
    in_data3   = 8'h00;
    in_sel3    = 2'd0;
    out_ready3 = 3'b000;

    // Reset state
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_drop_count", 32'(drop_count), 32'h0);
    check("rst_in_ready_sel2", 32'(in_ready), 32'h1);
    #2 reset_n = 1'b1;
    step();

    // Load 0xA5 to channel 2 with no sinks ready
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    #1 check("a5_in_ready_before", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    #1;
    check("a5_out_valid", 32'(out_valid), 32'h4);
    check("a5_out_data", out_data, 32'h00A5_0000);
    check("a5_in_ready_after", 32'(in_ready), 32'h0);

    // Channel 1 full, drained and reloaded on the same edge
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    #1 check("ch1_first_valid", 32'(out_valid), 32'h6);
    out_ready = 4'b0010;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C;
    #1 check("ch1_in_ready_drain", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    check("ch1_replace_valid", 32'(out_valid), 32'h6);
    check("ch1_replace_data", out_data, 32'h00A5_3C00);

    // Held word stays stable while the sink stalls, and idle inputs do nothing
    in_sel = 2'd0; in_data = 8'hFF;
    step();
    step();
    check("stall_valid", 32'(out_valid), 32'h6);
    check("stall_data", out_data, 32'h00A5_3C00);

    // Drain channel 2: data keeps the last word though valid drops
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    #1;
    check("drain2_valid", 32'(out_valid), 32'h2);
    check("drain2_stale_data", out_data, 32'h00A5_3C00);
    out_ready = 4'b0010;
    step();
    out_ready = 4'b0000;
    #1 check("drain1_valid", 32'(out_valid), 32'h0);

    // Fill all four channels, then drain in order 3,0,2,1
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 8'(8'h10 + k);
      step();
    end
    in_valid = 1'b0;
    #1;
    check("fill_valid", 32'(out_valid), 32'hF);
    check("fill_data", out_data, 32'h1312_1110);

    out_ready = 4'b1000;
    #1 check("drain3_word", 32'(out_data[31:24]), 32'h13);
    step();
    check("drain3_mask", 32'(out_valid), 32'h7);
    out_ready = 4'b0001;
    #1 check("drain0_word", 32'(out_data[7:0]), 32'h10);
    step();
    check("drain0_mask", 32'(out_valid), 32'h6);
    out_ready = 4'b0100;
    #1 check("drain2_word", 32'(out_data[23:16]), 32'h12);
    step();
    check("drain2b_mask", 32'(out_valid), 32'h2);
    out_ready = 4'b0010;
    #1 check("drain1_word", 32'(out_data[15:8]), 32'h11);
    step();
    check("drain1b_mask", 32'(out_valid), 32'h0);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check("drain_once", 32'(out_valid), 32'h0);

    // Three-channel instance: select 3 is out of range and dropped
    in_valid3 = 1'b1; in_sel3 = 2'd0; in_data3 = 8'h99;
    step();
    in_sel3 = 2'd3; in_data3 = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      #1 check("oor_in_ready", 32'(in_ready3), 32'h1);
      step();
      check("oor_pulse", 32'(drop_pulse3), 32'h1);
      check("oor_count", 32'(drop_count3), 32'(i + 1));
    end
    in_valid3 = 1'b0;
    step();
    check("oor_pulse_end", 32'(drop_pulse3), 32'h0);
    check("oor_count_hold", 32'(drop_count3), 32'h5);
    check("oor_valid", 32'(out_valid3), 32'h1);
    check("oor_data", 32'(out_data3), 32'h0000_0099);

    // Saturation: 300 further drops
    in_valid3 = 1'b1;
    for (int i = 0; i < 250; i++) step();
    check("sat_reach", 32'(drop_count3), 32'hFF);
    for (int i = 0; i < 50; i++) step();
    check("sat_hold", 32'(drop_count3), 32'hFF);
    check("sat_pulse", 32'(drop_pulse3), 32'h1);
    in_valid3 = 1'b0;
    step();

    // Asynchronous reset mid-cycle with held words
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55;
    step();
    in_sel = 2'd3; in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'h9);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data", out_data, 32'h0);
    check("async_rst_count3", 32'(drop_count3), 32'h0);
    check("async_rst_valid3", 32'(out_valid3), 32'h0);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h66;
    #1 check("rst_in_ready", 32'(in_ready), 32'h1);
    step();
    check("rst_no_load", 32'(out_valid), 32'h0);
    in_valid = 1'b0;
    #3 reset_n = 1'b1;
    step();
    step();
    check("post_rst_valid", 32'(out_valid), 32'h0);
    check("post_rst_count", 32'(drop_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_array.md
DEMUX_ARRAY -- requirements
Module: demux_array

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, width of each data word.
REQ-002 Parameter NUM_OUT, default 4, number of output channels; legal range 2..16.
REQ-003 Parameter SEL_WIDTH, default $clog2(NUM_OUT), width of the channel select.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  source word present.
REQ-007 in_ready  output  1  word accepted when in_valid && in_ready at a rising edge.
REQ-008 in_data  input  DATA_WIDTH  source word.
REQ-009 in_sel  input  SEL_WIDTH  destination channel index.
REQ-010 out_valid  output  NUM_OUT  bit k: channel k holds a word.
REQ-011 out_ready  input  NUM_OUT  bit k: sink k takes its word this cycle.
REQ-012 out_data  output  NUM_OUT*DATA_WIDTH  flattened; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 drop_pulse  output  1  one-cycle pulse on each word dropped for an out-of-range select.
REQ-014 drop_count  output  8  saturating count of dropped words.

Function
REQ-015 Each channel SHALL hold exactly one word in a holding register with a full flag driving out_valid[k].
REQ-016 A channel transfer SHALL occur when out_valid[k] && out_ready[k] at a rising edge, clearing full[k] unless a new word loads in the same edge.
REQ-017 in_ready SHALL be combinational: 1 when in_sel >= NUM_OUT, else (!full[in_sel] || out_ready[in_sel]).
REQ-018 An accepted word with in_sel < NUM_OUT SHALL appear on channel in_sel with out_valid set on the cycle after acceptance (latency 1).
REQ-019 Simultaneous drain and load on the same channel SHALL replace the word with no bubble; full stays 1.
REQ-020 Only the selected channel SHALL change on a load; other channels' data and valid SHALL be unaffected except by their own drains.
REQ-021 out_data[k] SHALL be stable while out_valid[k]=1 and out_ready[k]=0.
REQ-022 out_data[k] while out_valid[k]=0 SHALL be the last word held (zero after reset); sinks must not sample it.
REQ-023 Accepted words with in_sel >= NUM_OUT SHALL be discarded, assert drop_pulse for one cycle, and increment drop_count.
REQ-024 drop_count SHALL saturate at 255 and not wrap.
REQ-025 in_ready SHALL NOT depend on in_valid; in_data and in_sel changes without in_valid SHALL have no effect.
REQ-026 Ordering within one channel SHALL be preserved; no ordering is guaranteed across channels.

Reset
REQ-027 On reset_n low, SHALL immediately clear all full flags, out_valid, out_data, drop_pulse and drop_count to 0, independent of clk.
REQ-028 Reset asserted mid-transfer SHALL discard all held words; no word SHALL be delivered after reset is released without a new acceptance.
REQ-029 During reset, in_ready SHALL follow REQ-017 with all channels empty, but no load SHALL occur.

Structure
REQ-030 `DATA_WIDTH SHALL come from the shared defines header; no new global constants are required.
REQ-031 The per-channel holding register, full flag, and load/drain logic SHALL be a sub-module demux_slot, instantiated NUM_OUT times in a generate loop.
REQ-032 Select decode and the drop counter SHALL be in demux_array; no tri-state or tran primitives SHALL be used.

Verification
REQ-033 Reset, then send 0xA5 to sel=2 with all out_ready=0 -> out_valid=4'b0100 next cycle, out_data[23:16]=0xA5, in_ready for sel=2 falls to 0.
REQ-034 Channel 1 full, out_ready[1]=1, send 0x3C to sel=1 -> accepted same edge, out_valid[1] stays 1, data becomes 0x3C.
REQ-035 NUM_OUT=3, send sel=3 five times -> in_ready=1 each time, five drop_pulse cycles, drop_count=5, out_valid unchanged.
REQ-036 Fill all four channels with 0x10..0x13, then drain in order 3,0,2,1 -> each channel delivers only its own word, once.
REQ-037 Send 300 out-of-range words -> drop_count reads 255 and holds.
REQ-038 Load channels 0 and 3, assert reset_n low between clock edges -> out_valid=0 and drop_count=0 immediately; after release, out_valid stays 0.
